// File: rtl/mc_control_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
// The master modport is the controller side; the slave modport is the datapath side.
interface mc_control_fsm_if #(
    parameter int OPW   = 6,
    parameter int CNT_W = 32
);
    logic [OPW-1:0]   opcode;
    logic             zero;
    logic             mem_ready;
    logic             mem_req;
    logic             PCWrite;
    logic             Branch;
    logic             BranchNe;
    logic             IRWrite;
    logic             ALUSrcA;
    logic [1:0]       ALUSrcB;
    logic [1:0]       ALUop;
    logic [1:0]       PCSrc;
    logic             MemtoReg;
    logic             RegDst;
    logic             RegWrite;
    logic             MemWrite;
    logic             ExtSel;
    logic             halted;
    logic             err;
    logic [3:0]       state_o;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] ret_cnt;

    modport master (
        input  opcode, zero, mem_ready,
        output mem_req, PCWrite, Branch, BranchNe, IRWrite, ALUSrcA, ALUSrcB,
               ALUop, PCSrc, MemtoReg, RegDst, RegWrite, MemWrite, ExtSel,
               halted, err, state_o, cyc_cnt, ret_cnt
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  mem_req, PCWrite, Branch, BranchNe, IRWrite, ALUSrcA, ALUSrcB,
               ALUop, PCSrc, MemtoReg, RegDst, RegWrite, MemWrite, ExtSel,
               halted, err, state_o, cyc_cnt, ret_cnt
    );
endinterface

// File: rtl/mc_control_fsm.sv
// Memory-handshaked multicycle control FSM with bounded mem_ready waits and sticky HALT/ERR.
// Define PERF_CNT_EN to build the cycle and retired-instruction counters.
module mc_control_fsm #(
    parameter int OPW        = 6,
    parameter int TO_W       = 8,
    parameter int WAIT_LIMIT = 200,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    mc_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
        S_IWB    = 4'd12,
        S_HALT   = 4'd13,
        S_ERR    = 4'd14
    } state_t;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(6'b111111);

    state_t          r_state;
    state_t          w_state_next;
    logic [TO_W-1:0] r_to_cnt;
    logic [TO_W-1:0] w_to_next;
    logic            r_bne;
    logic            r_ori;
    logic            w_wait;
    logic            w_timeout;

    // The ALU zero flag gates the PC enable inside the datapath, not here.
    wire w_unused_zero = bus.zero;

    assign w_wait    = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_timeout = (r_to_cnt == TO_W'(WAIT_LIMIT));
    assign w_to_next = (w_wait && !bus.mem_ready && (w_state_next == r_state))
                       ? r_to_cnt + 1'b1 : '0;
    assign bus.state_o = r_state;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_to_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_to_cnt <= w_to_next;
        end
    end

    // BRANCH and IWB run after the opcode sampling window, so the variant is captured in DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bne <= 1'b0;
            r_ori <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_bne <= (bus.opcode == OP_BNE);
            r_ori <= (bus.opcode == OP_ORI);
        end
    end

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        w_state_next = r_state;
        bus.mem_req  = 1'b0;
        bus.PCWrite  = 1'b0;
        bus.Branch   = 1'b0;
        bus.BranchNe = 1'b0;
        bus.IRWrite  = 1'b0;
        bus.ALUSrcA  = 1'b0;
        bus.ALUSrcB  = 2'b00;
        bus.ALUop    = 2'b00;
        bus.PCSrc    = 2'b00;
        bus.MemtoReg = 1'b0;
        bus.RegDst   = 1'b0;
        bus.RegWrite = 1'b0;
        bus.MemWrite = 1'b0;
        bus.ExtSel   = 1'b1;
        bus.halted   = 1'b0;
        bus.err      = 1'b0;

        case (r_state)
            S_IDLE: w_state_next = S_FETCH;
            S_FETCH: begin
                bus.mem_req = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready;
                bus.PCWrite = bus.mem_ready;
                if (bus.mem_ready)  w_state_next = S_DECODE;
                else if (w_timeout) w_state_next = S_ERR;
            end
            S_DECODE: begin
                bus.ALUSrcB = 2'b11;
                case (bus.opcode)
                    OP_LW, OP_SW:     w_state_next = S_MEMADR;
                    OP_RTYPE:         w_state_next = S_EXEC;
                    OP_BEQ, OP_BNE:   w_state_next = S_BRANCH;
                    OP_J:             w_state_next = S_JUMP;
                    OP_ADDI, OP_ORI:  w_state_next = S_IEXEC;
                    OP_HALT:          w_state_next = S_HALT;
                    default:          w_state_next = S_ERR;
                endcase
            end
            S_MEMADR: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b10;
                w_state_next = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                if (bus.mem_ready)  w_state_next = S_MEMWB;
                else if (w_timeout) w_state_next = S_ERR;
            end
            S_MEMWB: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWR: begin
                bus.mem_req  = 1'b1;
                bus.MemWrite = bus.mem_ready;
                if (bus.mem_ready)  w_state_next = S_FETCH;
                else if (w_timeout) w_state_next = S_ERR;
            end
            S_EXEC: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUop    = 2'b10;
                w_state_next = S_RWB;
            end
            S_RWB: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
                w_state_next = S_FETCH;
            end
            S_BRANCH: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUop    = 2'b01;
                bus.PCSrc    = 2'b01;
                bus.Branch   = !r_bne;
                bus.BranchNe = r_bne;
                w_state_next = S_FETCH;
            end
            S_JUMP: begin
                bus.PCWrite  = 1'b1;
                bus.PCSrc    = 2'b10;
                w_state_next = S_FETCH;
            end
            S_IEXEC: begin
                bus.ALUSrcA  = 1'b1;
                bus.ALUSrcB  = 2'b10;
                bus.ALUop    = r_ori ? 2'b11 : 2'b00;
                bus.ExtSel   = !r_ori;
                w_state_next = S_IWB;
            end
            S_IWB: begin
                bus.RegWrite = 1'b1;
                bus.ExtSel   = !r_ori;
                w_state_next = S_FETCH;
            end
            S_HALT: bus.halted = 1'b1;
            S_ERR:  bus.err    = 1'b1;
            default: w_state_next = S_ERR;
        endcase
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_cyc_cnt;
    logic [CNT_W-1:0] r_ret_cnt;
    logic             w_active;
    logic             w_retire;

    assign w_active = !((r_state == S_IDLE) || (r_state == S_HALT) || (r_state == S_ERR));
    assign w_retire = (w_state_next == S_FETCH) &&
                      (r_state inside {S_MEMWB, S_MEMWR, S_RWB, S_BRANCH, S_JUMP, S_IWB});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cyc_cnt <= '0;
            r_ret_cnt <= '0;
        end else begin
            if (w_active) r_cyc_cnt <= r_cyc_cnt + 1'b1;
            if (w_retire) r_ret_cnt <= r_ret_cnt + 1'b1;
        end
    end

    assign bus.cyc_cnt = r_cyc_cnt;
    assign bus.ret_cnt = r_ret_cnt;
`else
    assign bus.cyc_cnt = '0;
    assign bus.ret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: random instruction stream against an
// instruction-level trace model, then directed timeout, halt, illegal-opcode and async-reset steps.
module tb_mc_control_fsm;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;
    localparam logic [5:0] OP_BAD   = 6'b010000;
    localparam int         WAIT_LIMIT = 200;

    typedef struct packed {
        logic       mem_req;
        logic       PCWrite;
        logic       Branch;
        logic       BranchNe;
        logic       IRWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] ALUop;
        logic [1:0] PCSrc;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       MemWrite;
        logic       ExtSel;
        logic       halted;
        logic       err;
    } ctl_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int unsigned exp_cyc = 0;
    int unsigned exp_ret = 0;
    bit   cur_bne = 1'b0;
    bit   cur_ori = 1'b0;
    logic [5:0] ops [8] = '{OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW};

    mc_control_fsm_if #(.OPW(6), .CNT_W(32)) bus ();

    mc_control_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic ctl_t obs();
        ctl_t c;
        c.mem_req  = bus.mem_req;   c.PCWrite  = bus.PCWrite;
        c.Branch   = bus.Branch;    c.BranchNe = bus.BranchNe;
        c.IRWrite  = bus.IRWrite;   c.ALUSrcA  = bus.ALUSrcA;
        c.ALUSrcB  = bus.ALUSrcB;   c.ALUop    = bus.ALUop;
        c.PCSrc    = bus.PCSrc;     c.MemtoReg = bus.MemtoReg;
        c.RegDst   = bus.RegDst;    c.RegWrite = bus.RegWrite;
        c.MemWrite = bus.MemWrite;  c.ExtSel   = bus.ExtSel;
        c.halted   = bus.halted;    c.err      = bus.err;
        return c;
    endfunction

    // Control word the datapath needs in each step of an instruction.
    function automatic ctl_t exp_ctl(input int st, input logic rdy);
        ctl_t c;
        c = '0;
        c.ExtSel = 1'b1;
        case (st)
            1:  begin c.mem_req = 1; c.ALUSrcB = 2'b01; c.IRWrite = rdy; c.PCWrite = rdy; end
            2:  c.ALUSrcB = 2'b11;
            3:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            4:  c.mem_req = 1;
            5:  begin c.RegWrite = 1; c.MemtoReg = 1; end
            6:  begin c.mem_req = 1; c.MemWrite = rdy; end
            7:  begin c.ALUSrcA = 1; c.ALUop = 2'b10; end
            8:  begin c.RegWrite = 1; c.RegDst = 1; end
            9:  begin c.ALUSrcA = 1; c.ALUop = 2'b01; c.PCSrc = 2'b01;
                      c.Branch = !cur_bne; c.BranchNe = cur_bne; end
            10: begin c.PCWrite = 1; c.PCSrc = 2'b10; end
            11: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10;
                      c.ALUop = cur_ori ? 2'b11 : 2'b00; c.ExtSel = !cur_ori; end
            12: begin c.RegWrite = 1; c.ExtSel = !cur_ori; end
            13: c.halted = 1;
            14: c.err = 1;
            default: ;
        endcase
        return c;
    endfunction

    task automatic chk_val(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, o, e);
        end
    endtask

    task automatic chk_ctl(input string tag, input ctl_t o, input ctl_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic chk_counters(input string tag);
`ifdef PERF_CNT_EN
        chk_val({tag, "_cyc"}, bus.cyc_cnt, exp_cyc);
        chk_val({tag, "_ret"}, bus.ret_cnt, exp_ret);
`else
        chk_val({tag, "_cyc"}, bus.cyc_cnt, 32'd0);
        chk_val({tag, "_ret"}, bus.ret_cnt, 32'd0);
`endif
    endtask

    // One clock of the trace: drive at the falling edge, check 1 ns later.
    task automatic step(input int st, input logic rdy, input logic [5:0] op, input bit retire);
        @(negedge clk);
        bus.mem_ready = rdy;
        bus.opcode    = op;
        bus.zero      = 1'($urandom_range(0, 1));
        #1;
        chk_val($sformatf("state_s%0d", st), {28'd0, bus.state_o}, st);
        chk_ctl($sformatf("ctl_s%0d", st), obs(), exp_ctl(st, rdy));
        chk_counters($sformatf("cnt_s%0d", st));
        if (!(st inside {0, 13, 14})) exp_cyc++;
        if (retire) exp_ret++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;
        exp_cyc = 0;
        exp_ret = 0;
        #1;
        chk_val("rst_state", {28'd0, bus.state_o}, 0);
        chk_ctl("rst_ctl", obs(), exp_ctl(0, 1'b0));
        chk_counters("rst");
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_val("idle_state", {28'd0, bus.state_o}, 0);
        chk_ctl("idle_ctl", obs(), exp_ctl(0, 1'b0));
    endtask

    // Expected trace from the instruction-level timing rules: fetch (+waits), decode, class tail.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        cur_bne = (op == OP_BNE);
        cur_ori = (op == OP_ORI);
        for (int i = 0; i < fw; i++) step(1, 1'b0, 6'($urandom), 1'b0);
        step(1, 1'b1, 6'($urandom), 1'b0);
        step(2, 1'($urandom_range(0, 1)), op, 1'b0);
        case (op)
            OP_LW: begin
                step(3, 1'($urandom_range(0, 1)), op, 1'b0);
                for (int i = 0; i < mw; i++) step(4, 1'b0, op, 1'b0);
                step(4, 1'b1, op, 1'b0);
                step(5, 1'($urandom_range(0, 1)), op, 1'b1);
            end
            OP_SW: begin
                step(3, 1'($urandom_range(0, 1)), op, 1'b0);
                for (int i = 0; i < mw; i++) step(6, 1'b0, op, 1'b0);
                step(6, 1'b1, op, 1'b1);
            end
            OP_RTYPE: begin
                step(7, 1'($urandom_range(0, 1)), op, 1'b0);
                step(8, 1'($urandom_range(0, 1)), op, 1'b1);
            end
            OP_BEQ, OP_BNE: step(9, 1'($urandom_range(0, 1)), op, 1'b1);
            OP_J:           step(10, 1'($urandom_range(0, 1)), op, 1'b1);
            OP_ADDI, OP_ORI: begin
                step(11, 1'($urandom_range(0, 1)), op, 1'b0);
                step(12, 1'($urandom_range(0, 1)), op, 1'b1);
            end
            OP_HALT: for (int i = 0; i < 100; i++) step(13, 1'($urandom_range(0, 1)), op, 1'b0);
            default: for (int i = 0; i < 3; i++)   step(14, 1'($urandom_range(0, 1)), op, 1'b0);
        endcase
    endtask

    initial begin
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'd0;
        bus.zero      = 1'b0;

        // R-type with mem_ready tied high, then a random stream with random wait counts
        do_reset();
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 3);
        run_instr(OP_SW, 1, 0);
        run_instr(OP_BNE, 0, 0);
        run_instr(OP_BEQ, 0, 0);
        for (int n = 0; n < 60; n++) begin
            run_instr(ops[$urandom_range(0, 7)],
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                      int'($urandom_range(0, 3)));
        end

        // Fetch timeout: 201 waiting cycles land in ERR, which is sticky
        do_reset();
        for (int i = 0; i <= WAIT_LIMIT; i++) step(1, 1'b0, 6'($urandom), 1'b0);
        for (int i = 0; i < 5; i++) step(14, 1'($urandom_range(0, 1)), 6'($urandom), 1'b0);

        // mem_ready on the limit cycle completes the fetch normally
        do_reset();
        run_instr(OP_RTYPE, WAIT_LIMIT, 0);

        // Memory-read timeout
        do_reset();
        run_instr(OP_ADDI, 0, 0);
        step(1, 1'b1, 6'd0, 1'b0);
        step(2, 1'b0, OP_LW, 1'b0);
        step(3, 1'b0, OP_LW, 1'b0);
        for (int i = 0; i <= WAIT_LIMIT; i++) step(4, 1'b0, OP_LW, 1'b0);
        step(14, 1'b1, OP_LW, 1'b0);

        // HALT holds for 100 cycles; illegal opcode reaches ERR
        do_reset();
        run_instr(OP_HALT, 0, 0);
        do_reset();
        run_instr(OP_BAD, 1, 0);

        // Asynchronous reset mid-FETCH drops the strobes before the next rising edge
        do_reset();
        step(1, 1'b0, 6'd0, 1'b0);
        step(1, 1'b0, 6'd0, 1'b0);
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        chk_ctl("pre_async_ctl", obs(), exp_ctl(1, 1'b1));
        #1;
        reset = 1'b0;
        #1;
        exp_cyc = 0;
        exp_ret = 0;
        chk_val("async_state", {28'd0, bus.state_o}, 0);
        chk_ctl("async_ctl", obs(), exp_ctl(0, 1'b0));
        chk_counters("async");
        do_reset();
        run_instr(OP_ORI, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Parametrised multicycle control unit for the word-addressed 32-bit multicycle datapath. It replaces the fixed-timing controller with a memory-handshaked FSM: instruction fetch, load and store wait on mem_ready, and each wait has a bounded timeout. It adds bne, addi, ori and halt decoding, a sticky error state and optional performance counters. It sits between the instruction register opcode field and all datapath mux selects and write strobes.

Parameters:
OPW, 6, opcode field width.
TO_W, 8, width of the memory-wait timeout counter.
WAIT_LIMIT, 200, maximum number of cycles spent waiting on mem_ready before entering ERR; must be below 2^TO_W.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
opcode  in  OPW  instruction register bits [31:26]
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
mem_req  out  1  memory access request
PCWrite  out  1  unconditional PC load
Branch  out  1  PC load if zero=1 (beq)
BranchNe  out  1  PC load if zero=0 (bne)
IRWrite  out  1  instruction register load
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = B, 01 = constant 1, 10 = extended immediate, 11 = extended immediate (branch offset)
ALUop  out  2  00 = add, 01 = sub, 10 = funct-decoded, 11 = or
PCSrc  out  2  00 = ALU result, 01 = ALUOut, 10 = jump address
MemtoReg  out  1  1 = memory data, 0 = ALUOut
RegDst  out  1  1 = rd, 0 = rt
RegWrite  out  1  register file write
MemWrite  out  1  data memory write
ExtSel  out  1  1 = sign extend, 0 = zero extend
halted  out  1  FSM is in HALT
err  out  1  FSM is in ERR (sticky)
state_o  out  4  current state encoding, for debug
cyc_cnt  out  CNT_W  cycles since reset (see Optional Feature)
ret_cnt  out  CNT_W  retired instructions (see Optional Feature)

Behaviour:
- Moore outputs are decoded from state only; the exceptions are the mem_ready-qualified strobes below.
- Reset (reset=0), asynchronous: state = IDLE (0), timeout counter = 0. All outputs are 0; ExtSel = 1.
- IDLE: all strobes 0. Next state is FETCH unconditionally.
- FETCH (1): mem_req=1, ALUSrcA=0, ALUSrcB=01, ALUop=00, PCSrc=00.
  - IRWrite and PCWrite are asserted only in the cycle where mem_ready=1; the FSM then goes to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE (2): ALUSrcA=0, ALUSrcB=11, ALUop=00, ExtSel=1 (branch target into ALUOut). Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000000 (R-type) -> EXEC
  - 000100 (beq) or 000101 (bne) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) or 001101 (ori) -> IEXEC
  - 111111 -> HALT
  - any other opcode -> ERR
- MEMADR (3): ALUSrcA=1, ALUSrcB=10, ALUop=00, ExtSel=1. Next is MEMRD for lw, MEMWR for sw.
- MEMRD (4): mem_req=1. On mem_ready -> MEMWB.
- MEMWB (5): RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR (6): mem_req=1. MemWrite=1 only in the mem_ready cycle, then -> FETCH.
- EXEC (7): ALUSrcA=1, ALUSrcB=00, ALUop=10. Next RWB.
- RWB (8): RegWrite=1, MemtoReg=0, RegDst=1. Next FETCH.
- BRANCH (9): ALUSrcA=1, ALUSrcB=00, ALUop=01, PCSrc=01. Branch=1 for beq, BranchNe=1 for bne. Next FETCH.
- JUMP (10): PCWrite=1, PCSrc=10. Next FETCH.
- IEXEC (11): ALUSrcA=1, ALUSrcB=10.
  - addi: ALUop=00, ExtSel=1.
  - ori: ALUop=11, ExtSel=0.
  - Next IWB.
- IWB (12): RegWrite=1, MemtoReg=0, RegDst=0, ExtSel held as in IEXEC. Next FETCH.
- HALT (13): halted=1, all strobes 0, mem_req=0. Left only by reset.
- ERR (14): err=1, all strobes 0, mem_req=0. Left only by reset.
- Timeout counter:
  - Increments in each FETCH/MEMRD/MEMWR cycle that has mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When the counter equals WAIT_LIMIT and mem_ready=0, the next state is ERR.
  - mem_ready=1 in that same cycle wins: the access completes normally.
- Latency per instruction with mem_ready tied to 1: R-type 4, lw 5, sw 4, beq/bne 3, j 3, addi/ori 4 cycles. Each wait cycle adds 1.
- Reset asserted mid-access: the FSM returns to IDLE immediately; any in-flight strobe drops asynchronously.
- Opcode is sampled only in DECODE, MEMADR and IEXEC. The instruction register is stable in those states.

Optional Feature:
PERF_CNT_EN.
- Defined:
  - cyc_cnt increments every cycle outside IDLE/HALT/ERR.
  - ret_cnt increments on each transition into FETCH from a completing state (MEMWB, MEMWR-ready, RWB, BRANCH, JUMP, IWB).
  - Both counters wrap modulo 2^CNT_W and reset to 0.
- Undefined: cyc_cnt and ret_cnt are constant 0 and no counter flops are built.

Test Plan:
1. Reset low 3 cycles, mem_ready=1, opcode=000000: state_o 0 -> 1 -> 2 -> 7 -> 8 -> 1. RegWrite=1, RegDst=1 only in state 8. With PERF_CNT_EN, ret_cnt=1 after 5 cycles.
2. lw with mem_ready low for 3 cycles in MEMRD: state stays at 4 for 4 cycles, then MEMWB with RegWrite=1 and MemtoReg=1.
3. sw: MemWrite=1 for exactly one cycle, coincident with mem_ready, then FETCH.
4. bne, zero=0 and zero=1: BranchNe=1, PCSrc=01 in state 9 for both cases; PCWrite stays 0. beq gives Branch=1.
5. mem_ready held 0 in FETCH with WAIT_LIMIT=200: after 201 waiting cycles state_o=14 and err=1, and err holds until reset. A variant with mem_ready=1 on the limit cycle goes to DECODE instead.
6. Opcode 111111: halted=1 and no strobes for 100 cycles. Opcode 010000: err=1. Asynchronous reset mid-FETCH: outputs drop to 0 before the next clock edge.
